// File: rtl/multi_key_debouncer.sv
// Multi-channel key debouncer: sync, glitch filter, clean level,
// and one-cycle press / release / long-press strobes per channel.
module multi_key_debouncer #(
  parameter int CHANNELS       = 4,
  parameter int CLK_FREQ_MHZ   = 100,
  parameter int GLITCH_TIME_NS = 40,
  parameter int LONG_PRESS_US  = 1,
  parameter int KEY_ACTIVE_LOW = 0
) (
  input  logic                clk_i,
  input  logic                srst_n_i,
  input  logic [CHANNELS-1:0] key_i,
  output logic [CHANNELS-1:0] key_state_o,
  output logic [CHANNELS-1:0] key_pressed_stb_o,
  output logic [CHANNELS-1:0] key_released_stb_o,
  output logic [CHANNELS-1:0] key_long_stb_o
);

  localparam int WR = GLITCH_TIME_NS * CLK_FREQ_MHZ / 1000;
  localparam int W  = (WR < 1) ? 1 : WR;
  localparam int L  = LONG_PRESS_US * CLK_FREQ_MHZ;
  localparam int SW = $clog2(W + 1);
  localparam logic [SW-1:0] WM1 = SW'(W - 1);
  localparam logic REL = (KEY_ACTIVE_LOW != 0);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic          s1_q;
    logic          s2_q;
    logic          p;
    logic          acc;
    logic          state_q;
    logic          press_q;
    logic          rel_q;
    logic [SW-1:0] cnt_q;

    // p is the synchronised level with 1 meaning pressed
    assign p   = s2_q ^ REL;
    assign acc = (p != state_q) && (cnt_q == WM1);

    always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
        s1_q    <= REL;
        s2_q    <= REL;
        state_q <= 1'b0;
        cnt_q   <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        s1_q    <= key_i[g];
        s2_q    <= s1_q;
        press_q <= acc && p;
        rel_q   <= acc && !p;
        if (p == state_q || acc) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        if (acc) begin
          state_q <= p;
        end
      end
    end

    assign key_state_o[g]        = state_q;
    assign key_pressed_stb_o[g]  = press_q;
    assign key_released_stb_o[g] = rel_q;

    if (L > 0) begin : g_long
      localparam int LW = $clog2(L + 1);
      localparam logic [LW-1:0] LM = LW'(L);
      logic [LW-1:0] hold_q;
      logic          long_q;

      // a release edge clears the hold so it never coincides with long
      always_ff @(posedge clk_i) begin
        if (!srst_n_i || !state_q || acc) begin
          hold_q <= '0;
          long_q <= 1'b0;
        end else if (hold_q != LM) begin
          hold_q <= hold_q + 1'b1;
          long_q <= (hold_q == LM - 1'b1);
        end else begin
          long_q <= 1'b0;
        end
      end

      assign key_long_stb_o[g] = long_q;
    end else begin : g_nolong
      assign key_long_stb_o[g] = 1'b0;
    end
  end

endmodule
